// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// ctrl_unit : fetch/decode/execute microsequencer for the 9-bit datapath
// Revision  : 1.0
// ============================================================================
module ctrl_unit #(
    parameter logic [3:0] ALU_PASS_A = 4'd0,
    parameter logic [3:0] ALU_ADD    = 4'd1,
    parameter logic [3:0] ALU_SUB    = 4'd2,
    parameter logic [3:0] ALU_PASS_B = 4'd3,
    parameter logic [1:0] MUXB_TR    = 2'd0,
    parameter logic [1:0] MUXB_AC    = 2'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] ir,
    input  logic       lsb,
    input  logic       neg,
    output logic       inc_pc,
    output logic       write_pc,
    output logic       write_iar,
    output logic       inc_iar,
    output logic       write_idr,
    output logic       write_ir,
    output logic       write_tr,
    output logic       write_dram,
    output logic       off_dram,
    output logic       write_mar,
    output logic       write1_mdr,
    output logic       write2_mdr,
    output logic       write_ac,
    output logic [3:0] ctrlunit_to_decoder,
    output logic [3:0] select_mux_a,
    output logic [1:0] select_mux_b,
    output logic [3:0] alu_sel,
    output logic       halted
);

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_LDAC  = 5'h01;
    localparam logic [4:0] OP_ADD   = 5'h02;
    localparam logic [4:0] OP_SUB   = 5'h03;
    localparam logic [4:0] OP_ADDT  = 5'h04;
    localparam logic [4:0] OP_STR   = 5'h05;
    localparam logic [4:0] OP_LOAD  = 5'h06;
    localparam logic [4:0] OP_STORE = 5'h07;
    localparam logic [4:0] OP_LDI   = 5'h08;
    localparam logic [4:0] OP_JMP   = 5'h09;
    localparam logic [4:0] OP_JN    = 5'h0A;
    localparam logic [4:0] OP_JL    = 5'h0B;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_EX1  = 4'd5,
        S_EX2  = 4'd6,
        S_EX3  = 4'd7,
        S_EX4  = 4'd8,
        S_EX5  = 4'd9,
        S_OP1  = 4'd10,
        S_OP2  = 4'd11,
        S_OP3  = 4'd12,
        S_HALT = 4'd13
    } state_t;

    typedef struct packed {
        logic       inc_pc;
        logic       write_iar;
        logic       write_idr;
        logic       write_ir;
        logic       write_tr;
        logic       write_dram;
        logic       off_dram;
        logic       write_mar;
        logic       write1_mdr;
        logic       write2_mdr;
        logic       write_ac;
        logic [3:0] decoder;
        logic [3:0] mux_a;
        logic [1:0] mux_b;
        logic [3:0] alu;
        logic       halted;
    } outs_t;

    state_t     r_state;
    outs_t      r_out;
    logic [4:0] r_op;
    logic [3:0] r_rf;
    logic [4:0] w_op;
    logic [3:0] w_rf;
    state_t     w_next;

    function automatic outs_t idle_outs();
        outs_t o;
        o          = '0;
        o.off_dram = 1'b1;
        return o;
    endfunction

    function automatic state_t next_state(input state_t s, input logic st, input logic [4:0] op);
        state_t n;
        n = s;
        case (s)
            S_IDLE: n = st ? S_F1 : S_IDLE;
            S_F1:   n = S_F2;
            S_F2:   n = S_F3;
            S_F3:   n = S_DEC;
            S_DEC: begin
                case (op)
                    OP_NOP:                                  n = S_F1;
                    OP_LDAC, OP_ADD, OP_SUB, OP_ADDT,
                    OP_STR, OP_LOAD, OP_STORE:               n = S_EX1;
                    OP_LDI, OP_JMP, OP_JN, OP_JL:            n = S_OP1;
                    OP_HALT:                                 n = S_HALT;
                    default:                                 n = S_F1;
                endcase
            end
            S_EX1:  n = S_EX2;
            S_EX2:  n = (op == OP_LOAD || op == OP_STORE) ? S_EX3 : S_F1;
            S_EX3:  n = S_EX4;
            S_EX4:  n = (op == OP_STORE) ? S_EX5 : S_F1;
            S_EX5:  n = S_F1;
            S_OP1:  n = S_OP2;
            S_OP2:  n = S_OP3;
            S_OP3:  n = S_F1;
            S_HALT: n = st ? S_F1 : S_HALT;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Outputs for the state about to be entered; registered so they line up with it.
    function automatic outs_t decode(input state_t s, input logic [4:0] op, input logic [3:0] rf);
        outs_t o;
        o = idle_outs();
        case (s)
            S_F1, S_OP1: o.write_iar = 1'b1;
            S_F2, S_OP2: begin
                o.write_idr = 1'b1;
                o.inc_pc    = 1'b1;
            end
            S_F3:   o.write_ir = 1'b1;
            S_EX1, S_EX2: begin
                case (op)
                    OP_LDAC: begin o.mux_a = rf; o.alu = ALU_PASS_A; end
                    OP_ADD:  begin o.mux_a = rf; o.mux_b = MUXB_AC; o.alu = ALU_ADD; end
                    OP_SUB:  begin o.mux_a = rf; o.mux_b = MUXB_AC; o.alu = ALU_SUB; end
                    OP_ADDT: begin o.mux_a = rf; o.mux_b = MUXB_TR; o.alu = ALU_ADD; end
                    OP_STR:  begin o.mux_b = MUXB_AC; o.alu = ALU_PASS_B; end
                    default: begin o.mux_a = rf; o.alu = ALU_PASS_A; end
                endcase
                // Destination strobe only once the registered ALU result is valid.
                if (s == S_EX2) begin
                    case (op)
                        OP_LDAC, OP_ADD, OP_SUB: o.write_ac  = 1'b1;
                        OP_ADDT, OP_STR:         o.decoder   = rf;
                        default:                 o.write_mar = 1'b1;
                    endcase
                end
            end
            S_EX3, S_EX4: begin
                if (op == OP_STORE) begin
                    o.mux_b      = MUXB_AC;
                    o.alu        = ALU_PASS_B;
                    o.write2_mdr = (s == S_EX4);
                end else begin
                    o.off_dram   = 1'b0;
                    o.write1_mdr = (s == S_EX4);
                end
            end
            S_EX5: begin
                o.write_dram = 1'b1;
                o.off_dram   = 1'b0;
            end
            S_OP3:  o.write_tr = (op == OP_LDI);
            S_HALT: o.halted = 1'b1;
            default: o = idle_outs();
        endcase
        return o;
    endfunction

    // IR is only guaranteed valid in DEC; later states use the copy taken there.
    assign w_op   = (r_state == S_DEC) ? ir[8:4] : r_op;
    assign w_rf   = (r_state == S_DEC) ? ir[3:0] : r_rf;
    assign w_next = next_state(r_state, start, w_op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_out   <= idle_outs();
            r_op    <= '0;
            r_rf    <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= decode(w_next, w_op, w_rf);
            if (r_state == S_DEC) begin
                r_op <= ir[8:4];
                r_rf <= ir[3:0];
            end
        end
    end

    // Conditional branches look at the live flags during OP3.
    assign write_pc = (r_state == S_OP3) &&
                      ((r_op == OP_JMP) || (r_op == OP_JN && neg) || (r_op == OP_JL && lsb));

    assign inc_pc              = r_out.inc_pc;
    assign inc_iar             = 1'b0;
    assign write_iar           = r_out.write_iar;
    assign write_idr           = r_out.write_idr;
    assign write_ir            = r_out.write_ir;
    assign write_tr            = r_out.write_tr;
    assign write_dram          = r_out.write_dram;
    assign off_dram            = r_out.off_dram;
    assign write_mar           = r_out.write_mar;
    assign write1_mdr          = r_out.write1_mdr;
    assign write2_mdr          = r_out.write2_mdr;
    assign write_ac            = r_out.write_ac;
    assign ctrlunit_to_decoder = r_out.decoder;
    assign select_mux_a        = r_out.mux_a;
    assign select_mux_b        = r_out.mux_b;
    assign alu_sel             = r_out.alu;
    assign halted              = r_out.halted;

endmodule
`default_nettype wire
